// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states
// and the helper that classifies multi-cycle operations.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        CEQ  = 3'd2,
        CLT  = 3'd3,
        PASS = 3'd4,
        SHLN = 3'd5,
        SHRN = 3'd6,
        MUL  = 3'd7
    } alu_seq_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(alu_seq_op_e op);
        return (op == SHLN) || (op == SHRN) || (op == MUL);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine for SHLN/SHRN/MUL: accumulator, counter, step.
// Ports: load/step control, captured op/operands/cin in; last flag
// and the post-step result (lo, hi, overflow) out.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  alu_seq_op_e      op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_ov
);

    logic [WIDTH-1:0] acc_q, acc_d, hi_q, hi_d, mc_q, mc_d;
    logic             ov_q, ov_d, cin_q, cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_seq_op_e      op_q, op_d;

    logic [WIDTH-1:0] acc_n, hi_n;
    logic             ov_n;
    logic [WIDTH:0]   psum;

    // One step of the selected operation. For MUL, {hi,acc} holds the
    // partial product with the multiplier draining out of acc's LSB.
    always_comb begin
        acc_n = acc_q;
        hi_n  = hi_q;
        ov_n  = ov_q;
        psum  = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mc_q} : '0);
        case (op_q)
            SHLN:    {ov_n, acc_n} = {acc_q, cin_q};
            SHRN:    {acc_n, ov_n} = {cin_q, acc_q};
            MUL:     {hi_n, acc_n} = {psum, acc_q[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        hi_d  = hi_q;
        mc_d  = mc_q;
        ov_d  = ov_q;
        cin_d = cin_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (load) begin
            op_d  = op;
            acc_d = (op == MUL) ? b : a;
            hi_d  = '0;
            mc_d  = a;
            ov_d  = 1'b0;
            cin_d = cin;
            cnt_d = (op == MUL) ? CNT_W'(WIDTH)
                                : {1'b0, b[CNT_W-2:0]};
        end else if (step) begin
            acc_d = acc_n;
            hi_d  = hi_n;
            ov_d  = ov_n;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            hi_q  <= '0;
            mc_q  <= '0;
            ov_q  <= 1'b0;
            cin_q <= 1'b0;
            cnt_q <= '0;
            op_q  <= ADD;
        end else begin
            acc_q <= acc_d;
            hi_q  <= hi_d;
            mc_q  <= mc_d;
            ov_q  <= ov_d;
            cin_q <= cin_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    assign last   = (cnt_q == CNT_W'(1));
    assign res_lo = acc_n;
    assign res_hi = (op_q == MUL) ? hi_n : '0;
    assign res_ov = (op_q == MUL) ? (|hi_n) : ov_n;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with FLAG/OVERFLOW registers and START/BUSY/DONE handshake.
// Ports: CLK, RESET_N, START, OP, CARRY_EN, INPUTA, INPUTB in;
// BUSY, DONE, OUT, OUT_HI, FLAG, OVERFLOW out.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic             CARRY_EN,
    input  logic [WIDTH-1:0] INPUTA,
    input  logic [WIDTH-1:0] INPUTB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             FLAG,
    output logic             OVERFLOW
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
    logic             flag_q, flag_d, ov_q, ov_d;

    alu_seq_op_e      op;
    logic             cin, accept, multi;
    logic [WIDTH:0]   sum, diff;
    logic             it_last, it_ov;
    logic [WIDTH-1:0] it_lo, it_hi;

    assign op     = alu_seq_op_e'(OP);
    assign cin    = CARRY_EN & ov_q;
    assign accept = (state_q == IDLE) && START;
    // A shift by zero completes like a single-cycle op.
    assign multi  = is_multicycle(op) &&
                    ((op == MUL) || (INPUTB[CNT_W-2:0] != '0));
    assign sum    = {1'b0, INPUTA} + {1'b0, INPUTB} + {{WIDTH{1'b0}}, cin};
    // Bit WIDTH of the extended difference is the borrow.
    assign diff   = {1'b0, INPUTA} - {1'b0, INPUTB} - {{WIDTH{1'b0}}, cin};

    alu_seq_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .load   (accept && multi),
        .step   (state_q == EXEC),
        .op     (op),
        .a      (INPUTA),
        .b      (INPUTB),
        .cin    (cin),
        .last   (it_last),
        .res_lo (it_lo),
        .res_hi (it_hi),
        .res_ov (it_ov)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (START) state_d = multi ? EXEC : FIN;
            EXEC:    if (it_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q == EXEC);
        DONE = (state_q == FIN);
    end

    // Result registers load on the edge that enters FIN.
    always_comb begin
        out_d  = out_q;
        hi_d   = hi_q;
        flag_d = flag_q;
        ov_d   = ov_q;
        if (accept && !multi) begin
            hi_d = '0;
            unique case (op)
                ADD:  {ov_d, out_d} = sum;
                SUB:  {ov_d, out_d} = diff;
                CEQ:  begin
                    flag_d = (INPUTA == INPUTB);
                    out_d  = '0;
                    ov_d   = 1'b0;
                end
                CLT:  begin
                    flag_d = (INPUTA < INPUTB);
                    out_d  = '0;
                    ov_d   = 1'b0;
                end
                PASS: out_d = INPUTB;
                SHLN: out_d = INPUTA;
                SHRN: out_d = INPUTA;
                MUL:  out_d = INPUTA;
            endcase
        end else if ((state_q == EXEC) && it_last) begin
            out_d = it_lo;
            hi_d  = it_hi;
            ov_d  = it_ov;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            out_q  <= '0;
            hi_q   <= '0;
            flag_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            out_q  <= out_d;
            hi_q   <= hi_d;
            flag_q <= flag_d;
            ov_q   <= ov_d;
        end
    end

    assign OUT      = out_q;
    assign OUT_HI   = hi_q;
    assign FLAG     = flag_q;
    assign OVERFLOW = ov_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed ops with
// literal expectations plus a per-cycle reference-model comparison.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N, START, CARRY_EN;
    logic [2:0] OP;
    logic [7:0] INPUTA, INPUTB;
    logic       BUSY, DONE, FLAG, OVERFLOW;
    logic [7:0] OUT, OUT_HI;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    alu_seq #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .OP       (OP),
        .CARRY_EN (CARRY_EN),
        .INPUTA   (INPUTA),
        .INPUTB   (INPUTB),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .OUT      (OUT),
        .OUT_HI   (OUT_HI),
        .FLAG     (FLAG),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: architectural registers plus a countdown to DONE.
    int       pend = 0;
    int       lat;
    bit       m_done = 0;
    bit       was_done;
    bit [7:0] m_out = 0, m_hi = 0;
    bit       m_flag = 0, m_ov = 0;
    bit [7:0] p_out, p_hi;
    bit       p_flag, p_ov;

    task automatic model_eval(input bit [2:0] op, input bit [7:0] a,
                              input bit [7:0] b, input bit cin);
        int n, full, ext, prod;
        n      = b % 8;
        p_out  = 0;
        p_hi   = 0;
        p_flag = m_flag;
        p_ov   = m_ov;
        lat    = 1;
        case (op)
            ADD: begin
                full  = a + b + cin;
                p_out = full[7:0];
                p_ov  = full[8];
            end
            SUB: begin
                full  = a - b - cin;
                p_out = full[7:0];
                p_ov  = (a < b + cin);
            end
            CEQ: begin p_flag = (a == b); p_ov = 0; end
            CLT: begin p_flag = (a < b);  p_ov = 0; end
            PASS: p_out = b;
            SHLN: begin
                if (n == 0) p_out = a;
                else begin
                    full  = (a << n) | (cin ? ((1 << n) - 1) : 0);
                    p_out = full[7:0];
                    p_ov  = full[8];
                    lat   = n + 1;
                end
            end
            SHRN: begin
                if (n == 0) p_out = a;
                else begin
                    ext   = (cin ? (((1 << n) - 1) << 8) : 0) | a;
                    full  = ext >> n;
                    p_out = full[7:0];
                    p_ov  = (ext >> (n - 1)) & 1;
                    lat   = n + 1;
                end
            end
            default: begin
                prod  = a * b;
                p_out = prod[7:0];
                p_hi  = prod[15:8];
                p_ov  = (p_hi != 0);
                lat   = 9;
            end
        endcase
    endtask

    task automatic commit();
        m_out  = p_out;
        m_hi   = p_hi;
        m_flag = p_flag;
        m_ov   = p_ov;
        m_done = 1;
    endtask

    always @(posedge CLK) begin
        if (!RESET_N) begin
            m_out = 0; m_hi = 0; m_flag = 0; m_ov = 0;
            pend = 0; m_done = 0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) commit();
            end else if (!was_done && START) begin
                model_eval(OP, INPUTA, INPUTB, CARRY_EN & m_ov);
                if (lat == 1) commit();
                else pend = lat - 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", 16'(BUSY), 16'(pend > 0));
            check("done", 16'(DONE), 16'(m_done));
            check("out", 16'(OUT), 16'(m_out));
            check("out_hi", 16'(OUT_HI), 16'(m_hi));
            check("flag", 16'(FLAG), 16'(m_flag));
            check("ovf", 16'(OVERFLOW), 16'(m_ov));
        end
    end

    task automatic run(input string nm, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic cen, input int elat,
                       input logic [7:0] eo, input logic [7:0] eh,
                       input logic ef, input logic eov);
        int c;
        @(negedge CLK);
        START = 1; OP = op; INPUTA = a; INPUTB = b; CARRY_EN = cen;
        @(negedge CLK);
        START = 0;
        INPUTA = 8'($urandom);
        INPUTB = 8'($urandom);
        c = 1;
        while (!DONE && c < 40) begin
            @(negedge CLK);
            c++;
        end
        check({nm, "_lat"}, 16'(c), 16'(elat));
        check({nm, "_out"}, 16'(OUT), 16'(eo));
        check({nm, "_hi"}, 16'(OUT_HI), 16'(eh));
        check({nm, "_flag"}, 16'(FLAG), 16'(ef));
        check({nm, "_ovf"}, 16'(OVERFLOW), 16'(eov));
        check({nm, "_mdl"}, 16'({m_hi, m_out}), 16'({eh, eo}));
    endtask

    initial begin
        int dones, done_at;
        RESET_N = 0; START = 0; OP = 0; CARRY_EN = 0;
        INPUTA = 0; INPUTB = 0;
        @(posedge CLK);
        chk_en = 1;
        @(negedge CLK);
        check("rst_out", 16'(OUT), 16'h0);
        check("rst_bd", 16'({BUSY, DONE, FLAG, OVERFLOW}), 16'h0);
        RESET_N = 1;

        run("add1", ADD, 8'hF0, 8'h20, 0, 1, 8'h10, 8'h00, 0, 1);
        run("add2", ADD, 8'h01, 8'h01, 1, 1, 8'h03, 8'h00, 0, 0);
        run("sub1", SUB, 8'h05, 8'h07, 0, 1, 8'hFE, 8'h00, 0, 1);
        run("clt1", CLT, 8'h05, 8'h07, 0, 1, 8'h00, 8'h00, 1, 0);
        run("ceq1", CEQ, 8'h33, 8'h34, 0, 1, 8'h00, 8'h00, 0, 0);
        run("shl3", SHLN, 8'h81, 8'h03, 1, 4, 8'h08, 8'h00, 0, 0);
        run("shr0", SHRN, 8'h81, 8'h00, 0, 1, 8'h81, 8'h00, 0, 0);
        run("mulff", MUL, 8'hFF, 8'hFF, 0, 9, 8'h01, 8'hFE, 0, 1);
        run("mul12", MUL, 8'h0C, 8'h0A, 0, 9, 8'h78, 8'h00, 0, 0);
        run("add3", ADD, 8'hFF, 8'h01, 0, 1, 8'h00, 8'h00, 0, 1);
        run("shr2c", SHRN, 8'h81, 8'h0A, 1, 3, 8'hE0, 8'h00, 0, 0);
        run("add4", ADD, 8'hFF, 8'h01, 0, 1, 8'h00, 8'h00, 0, 1);
        run("shl7c", SHLN, 8'h01, 8'h07, 1, 8, 8'hFF, 8'h00, 0, 0);
        run("add5", ADD, 8'hFF, 8'h01, 0, 1, 8'h00, 8'h00, 0, 1);
        run("subc", SUB, 8'h10, 8'h0F, 1, 1, 8'h00, 8'h00, 0, 0);
        run("clt2", CLT, 8'h01, 8'h02, 0, 1, 8'h00, 8'h00, 1, 0);
        run("pass", PASS, 8'h12, 8'h5A, 0, 1, 8'h5A, 8'h00, 1, 0);
        run("add6", ADD, 8'hFF, 8'h02, 0, 1, 8'h01, 8'h00, 1, 1);
        run("shl0", SHLN, 8'h80, 8'h08, 0, 1, 8'h80, 8'h00, 1, 1);

        // START pulsed mid-MUL must be ignored.
        @(negedge CLK);
        START = 1; OP = MUL; INPUTA = 8'h0C; INPUTB = 8'h0A;
        CARRY_EN = 0;
        @(negedge CLK);
        START = 0;
        dones = 0; done_at = 0;
        for (int c = 1; c <= 14; c++) begin
            START = (c == 3);
            if (c == 3) begin
                OP = ADD; INPUTA = 8'h01; INPUTB = 8'h01;
            end
            if (DONE) begin
                dones++;
                done_at = c;
                check("ign_out", 16'(OUT), 16'h0078);
            end
            @(negedge CLK);
        end
        START = 0;
        check("ign_dones", 16'(dones), 16'd1);
        check("ign_at", 16'(done_at), 16'd9);

        // Reset in the middle of a MUL aborts it.
        run("ceq2", CEQ, 8'h55, 8'h55, 0, 1, 8'h00, 8'h00, 1, 0);
        @(negedge CLK);
        START = 1; OP = MUL; INPUTA = 8'hFF; INPUTB = 8'hFF;
        @(negedge CLK);
        START = 0;
        repeat (3) @(negedge CLK);
        RESET_N = 0;
        @(negedge CLK);
        check("rst_busy", 16'(BUSY), 16'h0);
        check("rst_res", 16'({OUT, 7'b0, FLAG}), 16'h0);
        check("rst_ovf", 16'({DONE, OVERFLOW}), 16'h0);
        RESET_N = 1;
        dones = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        check("rst_nodone", 16'(dones), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
